// File: rtl/cordic_floatingpoint_output_recovery_if.sv
// Host-side bundle of the CORDIC output recovery block:
// result strobe from the control logic plus the show-ahead queue read port.
interface cordic_floatingpoint_output_recovery_if #(
  parameter int W = 32
);
  logic         iData_valid;
  logic [3:0]   iRecovery_info;
  logic         iNo_rotation;
  logic [W-1:0] iX;
  logic [W-1:0] iY;
  logic         iRdreq;
  logic [31:0]  oX_fp;
  logic [31:0]  oY_fp;
  logic         oEmpty;
  logic         oFull;
  logic         oOverflow;

  modport master (
    output iData_valid, iRecovery_info, iNo_rotation,
    output iX, iY, iRdreq,
    input  oX_fp, oY_fp, oEmpty, oFull, oOverflow
  );

  modport slave (
    input  iData_valid, iRecovery_info, iNo_rotation,
    input  iX, iY, iRdreq,
    output oX_fp, oY_fp, oEmpty, oFull, oOverflow
  );
endinterface

// File: rtl/cordic_floatingpoint_output_recovery.sv
// Quadrant recovery of CORDIC fixed-point X/Y, conversion to IEEE-754
// single precision, and a show-ahead output queue for the host.
module cordic_floatingpoint_output_recovery #(
  parameter int W     = 32,
  parameter int FRAC  = 30,
  parameter int DEPTH = 4
) (
  input logic iClk,
  input logic iReset,
  cordic_floatingpoint_output_recovery_if.slave bus
);
  localparam int PW = $clog2(W);
  localparam int AW = $clog2(DEPTH);

  function automatic logic [PW-1:0] lod(input logic [W-1:0] m);
    lod = '0;
    for (int i = 0; i < W; i++)
      if (m[i]) lod = PW'(i);
  endfunction

  // leading one moved to the top of an extended word; the 23 bits
  // below it are the truncated mantissa, zeros shifted in from below
  function automatic logic [31:0] pack(
    input logic          s,
    input logic          z,
    input logic [W-1:0]  m,
    input logic [PW-1:0] p
  );
    logic [W+22:0] n;
    logic [7:0]    e;
    int            sh;
    sh = W - 1 - int'(p);
    n = {m, 23'd0} << sh;
    e = 8'(127 - FRAC + int'(p));
    pack = z ? 32'd0 : {s, e, n[W+21 -: 23]};
  endfunction

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic [W-1:0]      a_mag;
  logic [W-1:0]      b_mag;

  always_comb begin
    a_ext = {bus.iX[W-1], bus.iX};
    b_ext = {bus.iY[W-1], bus.iY};
    if (!bus.iNo_rotation) begin
      if (bus.iRecovery_info[0]) begin
        a_ext = {bus.iY[W-1], bus.iY};
        b_ext = {bus.iX[W-1], bus.iX};
      end
      if (bus.iRecovery_info[1]) a_ext = -a_ext;
      if (bus.iRecovery_info[2]) b_ext = -b_ext;
    end
    a_mag = W'(a_ext[W] ? -a_ext : a_ext);
    b_mag = W'(b_ext[W] ? -b_ext : b_ext);
  end

  logic         s1_valid, s1_sa, s1_sb;
  logic [W-1:0] s1_ma, s1_mb;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      s1_valid <= 1'b0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else begin
      s1_valid <= bus.iData_valid;
      s1_sa    <= bus.iRecovery_info[3] ? 1'b0 : a_ext[W];
      s1_sb    <= bus.iRecovery_info[3] ? 1'b0 : b_ext[W];
      s1_ma    <= bus.iRecovery_info[3] ? '0 : a_mag;
      s1_mb    <= bus.iRecovery_info[3] ? '0 : b_mag;
    end
  end

  logic          s2_valid, s2_sa, s2_sb, s2_za, s2_zb;
  logic [W-1:0]  s2_ma, s2_mb;
  logic [PW-1:0] s2_pa, s2_pb;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      s2_valid <= 1'b0;
      s2_sa    <= 1'b0;
      s2_sb    <= 1'b0;
      s2_za    <= 1'b1;
      s2_zb    <= 1'b1;
      s2_ma    <= '0;
      s2_mb    <= '0;
      s2_pa    <= '0;
      s2_pb    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sa    <= s1_sa;
      s2_sb    <= s1_sb;
      s2_za    <= ~|s1_ma;
      s2_zb    <= ~|s1_mb;
      s2_ma    <= s1_ma;
      s2_mb    <= s1_mb;
      s2_pa    <= lod(s1_ma);
      s2_pb    <= lod(s1_mb);
    end
  end

  logic        s3_valid;
  logic [31:0] s3_x, s3_y;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      s3_valid <= 1'b0;
      s3_x     <= '0;
      s3_y     <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_x     <= pack(s2_sa, s2_za, s2_ma, s2_pa);
      s3_y     <= pack(s2_sb, s2_zb, s2_mb, s2_pb);
    end
  end

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full, empty, pop, push_ok;
  logic [63:0]   head;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = bus.iRdreq && !empty;
  // a pop in the same cycle frees the slot a full queue would refuse
  assign push_ok = s3_valid && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge iClk) begin
    if (push_ok) mem[wr_ptr] <= {s3_x, s3_y};
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (s3_valid && !push_ok) overflow <= 1'b1;
    end
  end

  assign bus.oX_fp     = empty ? 32'd0 : head[63:32];
  assign bus.oY_fp     = empty ? 32'd0 : head[31:0];
  assign bus.oEmpty    = empty;
  assign bus.oFull     = full;
  assign bus.oOverflow = overflow;
endmodule

// File: tb/tb_cordic_floatingpoint_output_recovery.sv
// Self-checking bench: directed vectors plus randomized traffic checked
// against a queue-based behavioural model of recovery, conversion and buffering.
module tb_cordic_floatingpoint_output_recovery;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic iClk = 1'b0;
  logic iReset;

  cordic_floatingpoint_output_recovery_if #(.W(W)) bus ();

  cordic_floatingpoint_output_recovery #(
    .W(W), .FRAC(30), .DEPTH(DEPTH)
  ) dut (
    .iClk(iClk),
    .iReset(iReset),
    .bus(bus)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int          due;
    logic [63:0] v;
  } infl_t;

  infl_t       infl[$];
  logic [63:0] exp_q[$];
  bit          m_ovf;

  function automatic logic [31:0] to_fp(input longint v);
    longint     mag;
    longint     mant;
    int         p;
    logic [7:0] e;
    logic       s;
    if (v == 0) return 32'd0;
    s = (v < 0);
    mag = s ? -v : v;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = 8'(127 + p - 30);
    if (p >= 23) mant = (mag >> (p - 23)) & 64'h7FFFFF;
    else mant = (mag << (23 - p)) & 64'h7FFFFF;
    return {s, e, mant[22:0]};
  endfunction

  function automatic logic [63:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [3:0]  info,
    input logic        nr
  );
    longint a, b, t;
    if (info[3]) return 64'd0;
    a = longint'($signed(x));
    b = longint'($signed(y));
    if (!nr) begin
      if (info[0]) begin
        t = a;
        a = b;
        b = t;
      end
      if (info[1]) a = -a;
      if (info[2]) b = -b;
    end
    return {to_fp(a), to_fp(b)};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    infl.delete();
    exp_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int    c;
    bit    pop, has_push;
    infl_t it;
    if (iReset) begin
      model_clear();
      edge_n++;
      return;
    end
    c = exp_q.size();
    pop = bus.iRdreq && c > 0;
    has_push = infl.size() > 0 && infl[0].due == edge_n;
    if (pop) void'(exp_q.pop_front());
    if (has_push) begin
      it = infl.pop_front();
      if (c == DEPTH && !pop) m_ovf = 1'b1;
      else exp_q.push_back(it.v);
    end
    if (bus.iData_valid) begin
      it.due = edge_n + 3;
      it.v = model(bus.iX, bus.iY, bus.iRecovery_info, bus.iNo_rotation);
      infl.push_back(it);
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge iClk);
    model_edge();
    #1;
  endtask

  task automatic drive(
    input logic        dv,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [3:0]  info,
    input logic        nr,
    input logic        rd
  );
    bus.iData_valid    = dv;
    bus.iX             = x;
    bus.iY             = y;
    bus.iRecovery_info = info;
    bus.iNo_rotation   = nr;
    bus.iRdreq         = rd;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    iReset = 1'b1;
    model_clear();
    tick();
    tick();
    iReset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.oEmpty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 1", bus.oEmpty);
    end
    checks++;
    if (bus.oFull !== 1'b0) begin
      errors++;
      $display("FAIL reset_full: got %b expected 0", bus.oFull);
    end
    checks++;
    if (bus.oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b expected 0", bus.oOverflow);
    end
    checks++;
    if (bus.oX_fp !== 32'd0 || bus.oY_fp !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0",
               bus.oX_fp, bus.oY_fp);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vx[5]   = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                             32'h2000_0000, 32'h4000_0000};
    logic [31:0] vy[5]   = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000,
                             32'h0000_0000, 32'hC000_0000};
    logic [3:0]  vinf[5] = '{4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1000};
    logic        vnr[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex[5]   = '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000,
                             32'h3F00_0000, 32'h0000_0000};
    logic [31:0] ey[5]   = '{32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000,
                             32'h0000_0000, 32'h0000_0000};
    apply_reset();
    for (int v = 0; v < 5; v++) begin
      drive(1'b1, vx[v], vy[v], vinf[v], vnr[v], 1'b0);
      for (int k = 1; k <= 4; k++) begin
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (bus.oEmpty !== (k < 4)) begin
          errors++;
          $display("FAIL dir%0d_latency_edge%0d: empty=%b expected %b",
                   v, k, bus.oEmpty, (k < 4));
        end
      end
      checks++;
      if (bus.oX_fp !== ex[v] || bus.oY_fp !== ey[v]) begin
        errors++;
        $display("FAIL dir%0d_data: got %h/%h expected %h/%h",
                 v, bus.oX_fp, bus.oY_fp, ex[v], ey[v]);
      end
      bus.iRdreq = 1'b1;
      tick();
      bus.iRdreq = 1'b0;
      checks++;
      if (bus.oEmpty !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_pop_empty: got %b expected 1", v, bus.oEmpty);
      end
    end
  endtask

  task automatic test_random();
    logic        rd;
    logic [63:0] h;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rd = (c < 200) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      drive(1'($urandom % 2), rnd_val(), rnd_val(),
            4'($urandom), 1'($urandom % 4 == 0), rd);
      tick();
      checks++;
      if (bus.oEmpty !== (exp_q.size() == 0) ||
          bus.oFull !== (exp_q.size() == DEPTH) ||
          bus.oOverflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_flags@%0d: got e%b f%b o%b expected e%b f%b o%b",
                 c, bus.oEmpty, bus.oFull, bus.oOverflow,
                 exp_q.size() == 0, exp_q.size() == DEPTH, m_ovf);
      end
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        checks++;
        if ({bus.oX_fp, bus.oY_fp} !== h) begin
          errors++;
          $display("FAIL rnd_head@%0d: got %h/%h expected %h/%h",
                   c, bus.oX_fp, bus.oY_fp, h[63:32], h[31:0]);
        end
      end
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] want[5];
    logic [31:0] x;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      x = 32'(i + 1) << 26;
      want[i] = model(x, -x, 4'd0, 1'b0);
      drive(1'b1, x, -x, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.oFull !== 1'b1 || bus.oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_after4: got f%b o%b expected f1 o0",
               bus.oFull, bus.oOverflow);
    end
    tick();
    checks++;
    if (bus.oFull !== 1'b1 || bus.oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overflow: got f%b o%b expected f1 o1",
               bus.oFull, bus.oOverflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.oX_fp, bus.oY_fp} !== want[i]) begin
        errors++;
        $display("FAIL b2b_order%0d: got %h/%h expected %h/%h", i,
                 bus.oX_fp, bus.oY_fp, want[i][63:32], want[i][31:0]);
      end
      bus.iRdreq = 1'b1;
      tick();
    end
    bus.iRdreq = 1'b0;
    checks++;
    if (bus.oEmpty !== 1'b1 || bus.oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drained: got e%b o%b expected e1 o1",
               bus.oEmpty, bus.oOverflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [63:0] want[5];
    logic [31:0] x;
    int          order[4] = '{1, 2, 3, 4};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      x = 32'h0123_4567 + 32'(i * 32'h0110_0000);
      want[i] = model(x, ~x, 4'b0010, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      x = 32'h0123_4567 + 32'(i * 32'h0110_0000);
      drive(1'b1, x, ~x, 4'b0010, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    x = 32'h0123_4567 + 32'h0440_0000;
    drive(1'b1, x, ~x, 4'b0010, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.oFull !== 1'b1) begin
      errors++;
      $display("FAIL pp_full_before: got %b expected 1", bus.oFull);
    end
    bus.iRdreq = 1'b1;
    tick();
    bus.iRdreq = 1'b0;
    checks++;
    if (bus.oFull !== 1'b1 || bus.oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL pp_full_after: got f%b o%b expected f1 o0",
               bus.oFull, bus.oOverflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.oX_fp, bus.oY_fp} !== want[order[i]]) begin
        errors++;
        $display("FAIL pp_order%0d: got %h/%h expected %h/%h", i,
                 bus.oX_fp, bus.oY_fp,
                 want[order[i]][63:32], want[order[i]][31:0]);
      end
      bus.iRdreq = 1'b1;
      tick();
    end
    bus.iRdreq = 1'b0;
    checks++;
    if (bus.oEmpty !== 1'b1) begin
      errors++;
      $display("FAIL pp_drained: got %b expected 1", bus.oEmpty);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h1000_0000 << i, 32'h0800_0000, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0400_0000, 32'h0200_0000 << i, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (bus.oEmpty !== 1'b0) begin
      errors++;
      $display("FAIL ar_queued: empty=%b expected 0", bus.oEmpty);
    end
    #2;
    iReset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus.oEmpty !== 1'b1 || bus.oFull !== 1'b0 ||
        bus.oX_fp !== 32'd0 || bus.oY_fp !== 32'd0) begin
      errors++;
      $display("FAIL ar_immediate: got e%b f%b %h/%h expected e1 f0 0/0",
               bus.oEmpty, bus.oFull, bus.oX_fp, bus.oY_fp);
    end
    tick();
    iReset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.oEmpty !== 1'b1 || bus.oOverflow !== 1'b0) begin
        errors++;
        $display("FAIL ar_after%0d: got e%b o%b expected e1 o0",
                 i, bus.oEmpty, bus.oOverflow);
      end
    end
  endtask

  initial begin
    iReset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_push_pop_full();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
